// File: rtl/regfile_pkg.sv
// Shared constants for the register file: widths, the zero word/index and
// the enable encodings used on the write-back and decode interfaces.
package defines;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 5;
   localparam int REG_NUM = 32;

   localparam logic [31:0] ZERO_WORD  = 32'h0;
   localparam logic [4:0]  REG_ZERO   = 5'd0;
   localparam logic        WR_ENABLE  = 1'b1;
   localparam logic        WR_DISABLE = 1'b0;
   localparam logic        RD_ENABLE  = 1'b1;
   localparam logic        RD_DISABLE = 1'b0;
endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port of the register file. With REGFILE_BYPASS_EN
// defined, a same-cycle write to the addressed register is forwarded.
module regfile_rd_port
   import defines::*;
#(
   parameter int DATA_W = defines::DATA_W,
   parameter int ADDR_W = defines::ADDR_W
) (
   input  logic              rst,
   input  logic              re,
   input  logic [ADDR_W-1:0] rAddr,
   input  logic [DATA_W-1:0] memData,
   input  logic              we,
   input  logic [ADDR_W-1:0] wAddr,
   input  logic [DATA_W-1:0] wData,
   output logic [DATA_W-1:0] rData
);

`ifndef REGFILE_BYPASS_EN
   // Write-port signals only matter for forwarding.
   logic unused_wr;
   assign unused_wr = ^{we, wAddr, wData};
`endif

   always_comb begin
      rData = '0;
      if (rst && re == RD_ENABLE && rAddr != ADDR_W'(REG_ZERO)) begin
`ifdef REGFILE_BYPASS_EN
         if (we == WR_ENABLE && wAddr != ADDR_W'(REG_ZERO) && rAddr == wAddr)
            rData = wData;
         else
            rData = memData;
`else
         rData = memData;
`endif
      end
   end

endmodule

// File: rtl/regfile.sv
// MIPS general-purpose register file: one write port from WB, two
// combinational read ports to ID. Optional macro: REGFILE_BYPASS_EN.
module regfile
   import defines::*;
#(
   parameter int DATA_W  = defines::DATA_W,
   parameter int ADDR_W  = defines::ADDR_W,
   parameter int REG_NUM = defines::REG_NUM
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wAddr,
   input  logic [DATA_W-1:0] wData,
   input  logic              re1,
   input  logic [ADDR_W-1:0] rAddr1,
   output logic [DATA_W-1:0] rData1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] rAddr2,
   output logic [DATA_W-1:0] rData2
);

   logic [DATA_W-1:0] mem_q [REG_NUM];
   logic              wr_en_d;

   // Index 0 is never written, so it keeps its reset value of zero.
   assign wr_en_d = (we == WR_ENABLE) && (wAddr != ADDR_W'(REG_ZERO));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_NUM; i++) mem_q[i] <= '0;
      end else if (wr_en_d) begin
         mem_q[wAddr] <= wData;
      end
   end

   regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
      .rst(rst), .re(re1), .rAddr(rAddr1), .memData(mem_q[rAddr1]),
      .we(we), .wAddr(wAddr), .wData(wData), .rData(rData1)
   );

   regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
      .rst(rst), .re(re2), .rAddr(rAddr2), .memData(mem_q[rAddr2]),
      .we(we), .wAddr(wAddr), .wData(wData), .rData(rData2)
   );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed hazard/reset cases plus
// randomized traffic against an array-based reference model.
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, we, re1, re2;
   logic [4:0]  wAddr, rAddr1, rAddr2;
   logic [31:0] wData, rData1, rData2;
   logic [31:0] model [32];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   regfile dut (
      .clk(clk), .rst(rst), .we(we), .wAddr(wAddr), .wData(wData),
      .re1(re1), .rAddr1(rAddr1), .rData1(rData1),
      .re2(re2), .rAddr2(rAddr2), .rData2(rData2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_rd(input logic re, input logic [4:0] a);
      if (!rst || !re || a == 5'd0) return 32'h0;
      if (BYP && we && wAddr != 5'd0 && a == wAddr) return wData;
      return model[a];
   endfunction

   task automatic check_ports(input string tag);
      #1;
      chk({tag, "_p1"}, rData1, ref_rd(re1, rAddr1));
      chk({tag, "_p2"}, rData2, ref_rd(re2, rAddr2));
   endtask

   // Model commits the write on the same edge the DUT does.
   task automatic tick();
      @(posedge clk);
      if (rst && we && wAddr != 5'd0) model[wAddr] = wData;
      @(negedge clk);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   task automatic read_all(input string tag);
      we = 1'b0; re1 = 1'b1; re2 = 1'b1;
      for (int i = 0; i < 32; i++) begin
         rAddr1 = 5'(i); rAddr2 = 5'(31 - i);
         #1;
         chk({tag, "_p1"}, rData1, 32'h0);
         chk({tag, "_p2"}, rData2, 32'h0);
      end
   endtask

   initial begin
      rst = 1'b0; we = 1'b0; wAddr = '0; wData = '0;
      re1 = 1'b1; re2 = 1'b1; rAddr1 = 5'd3; rAddr2 = 5'd31;
      clear_model();

      // Reset held for three cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         we = 1'b1; wAddr = 5'd3; wData = 32'hCAFE0000 + 32'(i);
         #1;
         chk("rst_hold_p1", rData1, 32'h0);
         chk("rst_hold_p2", rData2, 32'h0);
      end
      we = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      read_all("post_rst");

      // Basic write/read
      we = 1'b1; wAddr = 5'd5; wData = 32'hDEADBEEF;
      tick();
      we = 1'b0; rAddr1 = 5'd5; rAddr2 = 5'd5;
      #1;
      chk("wr_p1", rData1, 32'hDEADBEEF);
      chk("wr_p2", rData2, 32'hDEADBEEF);
      re1 = 1'b0;
      #1 chk("re_off", rData1, 32'h0);
      re1 = 1'b1;

      // Writes to register 0 are dropped
      we = 1'b1; wAddr = 5'd0; wData = 32'hFFFFFFFF; rAddr1 = 5'd0;
      tick();
      we = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("zero_reg", rData1, 32'h0);
         tick();
      end

      // Same-cycle WB/ID hazard
      we = 1'b1; wAddr = 5'd7; wData = 32'h11111111;
      tick();
      wData = 32'h22222222; rAddr2 = 5'd7;
      #1 chk("haz_pre", rData2, BYP ? 32'h22222222 : 32'h11111111);
      tick();
      we = 1'b0;
      #1 chk("haz_post", rData2, 32'h22222222);

      // Fill, then async reset pulse between edges
      we = 1'b1;
      for (int i = 1; i < 32; i++) begin
         wAddr = 5'(i); wData = 32'(i);
         tick();
      end
      we = 1'b0; rAddr1 = 5'd17; rAddr2 = 5'd31;
      check_ports("filled");
      rst = 1'b0;
      #1;
      chk("async_rst_p1", rData1, 32'h0);
      chk("async_rst_p2", rData2, 32'h0);
      clear_model();
      #1 rst = 1'b1;
      read_all("after_pulse");

      // Back-to-back writes to one register
      @(negedge clk);
      we = 1'b1; wAddr = 5'd9; wData = 32'hA; re1 = 1'b1; rAddr1 = 5'd9;
      tick();
      #1 chk("b2b_first", rData1, 32'hA);
      wData = 32'hB;
      tick();
      we = 1'b0; rAddr2 = 5'd10;
      #1;
      chk("b2b_last", rData1, 32'hB);
      chk("b2b_r10", rData2, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         we     = ($urandom_range(0, 3) != 0);
         wAddr  = 5'($urandom_range(0, 31));
         wData  = $urandom;
         re1    = ($urandom_range(0, 7) != 0);
         re2    = ($urandom_range(0, 7) != 0);
         rAddr1 = ($urandom_range(0, 3) == 0) ? wAddr : 5'($urandom_range(0, 31));
         rAddr2 = ($urandom_range(0, 3) == 0) ? wAddr : 5'($urandom_range(0, 31));
         check_ports("rand");
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- Architectural general-purpose register file of the five-stage MIPS core.
- It is the consuming end of the write-back interface: it accepts the write enable, address and data driven by the write-back stage.
- It serves two combinational read ports to the decode stage.
- Register 0 is hardwired to zero, and an optional write-to-read bypass resolves the same-cycle WB/ID hazard.

Parameters:
- DATA_W, 32, register and data width in bits
- ADDR_W, 5, register address width
- REG_NUM, 32, number of registers (2**ADDR_W)

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- we  in  1  write enable from write-back stage
- wAddr  in  ADDR_W  write register index
- wData  in  DATA_W  write data
- re1  in  1  read enable, port 1 (rs)
- rAddr1  in  ADDR_W  read index, port 1
- rData1  out  DATA_W  read data, port 1
- re2  in  1  read enable, port 2 (rt)
- rAddr2  in  ADDR_W  read index, port 2
- rData2  out  DATA_W  read data, port 2

Behaviour:
- Reset: rst=0 asynchronously clears all REG_NUM registers to 0. While rst=0, rData1 and rData2 read 0 regardless of other inputs.
- Write: on posedge clk with rst=1, we=1 and wAddr!=0, mem[wAddr] <= wData. A write to index 0 is discarded. we=0 leaves the array unchanged.
- Write latency: 1 cycle. The value is visible from the array on the cycle after the edge.
- Read: purely combinational, 0-cycle latency. Each port is evaluated independently, by priority:
  1. rst=0 -> 0
  2. reN=0 -> 0
  3. rAddrN=0 -> 0
  4. bypass hit (see Optional Feature) -> wData
  5. otherwise -> mem[rAddrN]
- Both ports may read the same index in the same cycle, and both return identical data.
- Reset deasserting mid-cycle: the array stays zero until the first qualifying write edge. rst asserting at any time clears immediately, with no clock needed.
- X inputs on wAddr/wData while we=0 must not corrupt the array.
- No handshake: a write is accepted unconditionally every cycle we=1. There is no stall or backpressure.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when we=1, wAddr!=0, reN=1 and rAddrN==wAddr, port N returns wData in the same cycle (write-through). This removes the WB->ID hazard.
- Not defined: port N returns the pre-write contents of mem[rAddrN]. The new value appears the next cycle, and the pipeline must cover the hazard elsewhere.
- The feature has no effect on the write behaviour or on the reset behaviour.

Decomposition:
- Shared package `defines`:
  - constants DATA_W=32, ADDR_W=5, REG_NUM=32
  - ZERO_WORD=32'h0
  - REG_ZERO=5'd0
  - WR_ENABLE=1'b1, WR_DISABLE=1'b0, RD_ENABLE=1'b1, RD_DISABLE=1'b0
- One sub-module: `regfile_rd_port`.
  - Combinational read mux for one port.
  - Implements the priority chain above, including the REGFILE_BYPASS_EN branch.
  - Instantiated twice, once per port.
- The storage array and write logic live in the top module.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with re1=re2=1 and rAddr1=3, rAddr2=31 -> rData1=rData2=0. Release rst, do no writes, read all 32 indices -> all 0.
2. Basic write/read: we=1, wAddr=5, wData=32'hDEADBEEF at edge N; at N+1 read rAddr1=5, rAddr2=5 -> both 32'hDEADBEEF. With re1=0 -> rData1=0.
3. Zero register: we=1, wAddr=0, wData=32'hFFFFFFFF, then read rAddr1=0 with re1=1 -> 0 on every subsequent cycle.
4. Same-cycle hazard: mem[7]=32'h11111111; drive we=1, wAddr=7, wData=32'h22222222 with rAddr2=7 in the same cycle.
   - Before the edge: rData2=32'h22222222 with REGFILE_BYPASS_EN, 32'h11111111 without.
   - After the edge: 32'h22222222 in both builds.
5. Async reset mid-run: fill regs 1..31 with value=index, then pulse rst=0 between clock edges (no clk edge) -> rData immediately 0. After release, all regs read 0.
6. Back-to-back writes: write 32'hA to reg 9 and 32'hB to reg 9 on consecutive edges while re1=1, rAddr1=9 -> after the edges rData1=32'hA then 32'hB. The last write wins and reg 10 stays 0.
